// File: rtl/l2req_arbiter_queue.sv
// l2req_arbiter_queue
//   Queues packets from NUM_REQ requesters in per-requester FIFOs and hands
//   one head-of-queue packet per cycle to the core's single l2req port,
//   using either round-robin or fixed-priority arbitration. Once a packet is
//   presented and the L2 side stalls, the grant is locked, so the presented
//   packet stays the same until it is accepted.
//
//   Optional feature macro: L2REQ_ARB_PERF_COUNTERS_EN (adds stall/grant counters).
//
//   Ports:
//     clk, reset          clock, asynchronous active-low reset
//     req_valid/_packet   per-requester enqueue (requester i at [i*PACKET_WIDTH +: PACKET_WIDTH])
//     req_ready           FIFO i not full (registered state only)
//     l2req_valid/_packet/_source, l2req_ready   L2 request handshake
//     perf_stall_cycles, perf_grants             (feature macro only)

module l2req_fifo #(
   parameter int DEPTH = 2,
   parameter int W     = 128
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         wr_en,
   input  logic [W-1:0] wr_data,
   input  logic         rd_en,
   output logic         full,
   output logic         empty,
   output logic [W-1:0] head
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [DEPTH-1:0][W-1:0] mem_q, mem_d;
   logic [PW-1:0]           wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CW-1:0]           cnt_q, cnt_d;

   assign full  = (cnt_q == CW'(DEPTH));
   assign empty = (cnt_q == '0);
   assign head  = mem_q[rptr_q];

   // DEPTH is a power of two, so pointers wrap by natural overflow.
   always_comb begin
      mem_d  = mem_q;
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      cnt_d  = cnt_q;
      if (wr_en) begin
         mem_d[wptr_q] = wr_data;
         wptr_d        = wptr_q + PW'(1);
      end
      if (rd_en) rptr_d = rptr_q + PW'(1);
      case ({wr_en, rd_en})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q  <= '0;
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         mem_q  <= mem_d;
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cnt_q  <= cnt_d;
      end
   end
endmodule

module l2req_arbiter_queue #(
   parameter int NUM_REQ      = 3,
   parameter int QUEUE_DEPTH  = 2,
   parameter int PACKET_WIDTH = 128,
   parameter int ARB_MODE     = 0,
   localparam int SW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [NUM_REQ-1:0]              req_valid,
   input  logic [NUM_REQ*PACKET_WIDTH-1:0] req_packet,
   output logic [NUM_REQ-1:0]              req_ready,
   output logic                            l2req_valid,
   output logic [PACKET_WIDTH-1:0]         l2req_packet,
   output logic [SW-1:0]                   l2req_source,
   input  logic                            l2req_ready
`ifdef L2REQ_ARB_PERF_COUNTERS_EN
   ,
   output logic [31:0]                     perf_stall_cycles,
   output logic [NUM_REQ*32-1:0]           perf_grants
`endif
);
   typedef enum logic {IDLE, LOCKED} state_t;

   state_t                                 state_q, state_d;
   logic [SW-1:0]                          lock_q, lock_d, rr_q, rr_d;
   logic [SW-1:0]                          winner, cand, sel, rr_nxt;
   logic                                   found, any_ne, accept;
   logic [NUM_REQ-1:0]                     full, empty, rd_en;
   logic [NUM_REQ-1:0][PACKET_WIDTH-1:0]   head;

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_q
      assign req_ready[i] = !full[i];
      assign rd_en[i]     = accept && (sel == SW'(i));
      l2req_fifo #(.DEPTH(QUEUE_DEPTH), .W(PACKET_WIDTH)) u_fifo (
         .clk     (clk),
         .rst_n   (reset),
         .wr_en   (req_valid[i] && !full[i]),
         .wr_data (req_packet[i*PACKET_WIDTH +: PACKET_WIDTH]),
         .rd_en   (rd_en[i]),
         .full    (full[i]),
         .empty   (empty[i]),
         .head    (head[i])
      );
   end

   // Scan candidates starting at the RR pointer (or index 0 in priority mode);
   // first non-empty FIFO wins.
   always_comb begin
      winner = '0;
      cand   = '0;
      found  = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (ARB_MODE == 0) cand = SW'((int'(rr_q) + k) % NUM_REQ);
         else               cand = SW'(k);
         if (!found && !empty[cand]) begin
            found  = 1'b1;
            winner = cand;
         end
      end
   end

   assign any_ne       = ~&empty;
   assign sel          = (state_q == LOCKED) ? lock_q : winner;
   assign l2req_valid  = (state_q == LOCKED) || any_ne;
   assign accept       = l2req_valid && l2req_ready;
   assign l2req_packet = l2req_valid ? head[sel] : '0;
   assign l2req_source = l2req_valid ? sel : '0;
   assign rr_nxt       = (int'(sel) + 1 >= NUM_REQ) ? '0 : sel + SW'(1);

   always_comb begin
      state_d = state_q;
      lock_d  = lock_q;
      rr_d    = rr_q;
      if (accept) rr_d = rr_nxt;
      case (state_q)
         IDLE:    if (any_ne && !l2req_ready) begin
                     state_d = LOCKED;
                     lock_d  = winner;
                  end
         LOCKED:  if (l2req_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         lock_q  <= '0;
         rr_q    <= '0;
      end else begin
         state_q <= state_d;
         lock_q  <= lock_d;
         rr_q    <= rr_d;
      end
   end

`ifdef L2REQ_ARB_PERF_COUNTERS_EN
   logic [31:0]              stall_q, stall_d;
   logic [NUM_REQ-1:0][31:0] grants_q, grants_d;

   always_comb begin
      stall_d  = stall_q;
      grants_d = grants_q;
      if (l2req_valid && !l2req_ready) stall_d = stall_q + 32'd1;
      if (accept) grants_d[sel] = grants_q[sel] + 32'd1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_q  <= '0;
         grants_q <= '0;
      end else begin
         stall_q  <= stall_d;
         grants_q <= grants_d;
      end
   end

   assign perf_stall_cycles = stall_q;
   assign perf_grants       = grants_q;
`endif
endmodule

// File: doc/l2req_arbiter_queue.md
Name: l2req_arbiter_queue

Overview:
- Parametrised successor to the fixed three-input L2 request arbiter.
- Accepts packets from NUM_REQ requesters (icache, dcache, store buffer, plus future IO/coprocessor ports) into per-requester FIFOs of depth QUEUE_DEPTH.
- Selects one head-of-queue packet per cycle by round-robin or fixed priority and drives the core's single l2req interface.
- Holds the grant locked while the L2 side stalls, so a presented packet never changes before it is accepted.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- QUEUE_DEPTH, 2, entries per requester FIFO (power of two, 2..16).
- PACKET_WIDTH, 128, bits per flattened l2req packet.
- ARB_MODE, 0, 0 = round-robin, 1 = fixed priority (lowest index wins).

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  NUM_REQ  per-requester packet valid.
- req_packet  input  NUM_REQ*PACKET_WIDTH  requester i occupies bits [i*PACKET_WIDTH +: PACKET_WIDTH].
- req_ready  output  NUM_REQ  FIFO i can accept a packet this cycle.
- l2req_valid  output  1  packet presented to L2.
- l2req_packet  output  PACKET_WIDTH  selected packet.
- l2req_source  output  $clog2(NUM_REQ)  index of the granted requester.
- l2req_ready  input  1  L2 accepts the packet this cycle.

Behaviour:
- Reset (reset low, asynchronous assertion; deassertion sampled on clk):
  - All FIFOs empty; RR pointer = 0; state IDLE.
  - Outputs: l2req_valid = 0, l2req_packet = 0, l2req_source = 0, req_ready = all ones.
  - Reset mid-operation discards every queued and locked packet. The L2 side must treat an in-flight l2req_valid as withdrawn.
- Enqueue:
  - Occurs when req_valid[i] && req_ready[i] at a clk edge.
  - req_ready[i] = !full[i]. It depends only on registered state, with no combinational path from l2req_ready.
  - A full FIFO holds req_ready low until it is dequeued.
- Count:
  - Per-FIFO occupancy counter of width $clog2(QUEUE_DEPTH)+1.
  - Enqueue and dequeue in the same cycle leave the count unchanged.
  - Read and write pointers wrap modulo QUEUE_DEPTH.
- Latency: a packet enqueued at edge N is earliest visible on l2req at cycle N+1 (registered FIFO storage, combinational head read).
- State machine:
  - IDLE:
    - l2req_valid = (any FIFO non-empty).
    - The arbiter picks a winner combinationally: RR mode takes the first non-empty index at or after the RR pointer, modulo NUM_REQ; priority mode takes the lowest non-empty index.
    - l2req_packet and l2req_source reflect the winner.
    - If l2req_ready: dequeue the winner, remain IDLE, set RR pointer = winner+1 (mod NUM_REQ).
    - If !l2req_ready: register the winner index and go to LOCKED.
  - LOCKED:
    - Output the locked requester's head; l2req_valid = 1.
    - No re-arbitration, even if higher-priority requests arrive.
    - On l2req_ready: dequeue, update the RR pointer as above, return to IDLE.
- RR pointer advances only on an accepted transfer; stalled cycles do not move it.
- l2req_packet = 0 whenever l2req_valid = 0.
- Simultaneous enqueue to an empty FIFO and arbitration in the same cycle: the new packet is not visible until the next cycle (no bypass).
- NUM_REQ = 1 degenerates to a FIFO; l2req_source is held at width 1 and is constant 0.

Optional Feature:
- Macro L2REQ_ARB_PERF_COUNTERS_EN.
- Defined:
  - Adds output perf_stall_cycles[31:0]: increments on each cycle with l2req_valid && !l2req_ready.
  - Adds output perf_grants[NUM_REQ*32-1:0]: per-requester counters increment on each accepted transfer.
  - All counters reset to 0 and wrap at 2^32.
- Undefined: neither port nor any counter logic exists; behaviour is otherwise identical.

Test Plan:
- Reset/idle: hold reset low 3 cycles, release, no requests -> l2req_valid = 0, req_ready = 3'b111, l2req_packet = 0 for 10 cycles.
- Round-robin fairness: ARB_MODE=0, all 3 requesters keep FIFOs non-empty, l2req_ready = 1 -> l2req_source sequence 0,1,2,0,1,2; each perf_grants counter = 2 after 6 transfers (feature on).
- Stall lock: requester 2 alone, l2req_ready = 0 for 4 cycles; requester 0 enqueues during the stall -> source stays 2 with a stable packet for all 4 cycles; after accept, the next source = 0; perf_stall_cycles = 4.
- Full/backpressure: QUEUE_DEPTH=2, requester 1 sends 3 packets A,B,C back-to-back with l2req_ready = 0 -> req_ready[1] drops after B; C is held; after raising l2req_ready, L2 receives A,B,C in order.
- Fixed priority: ARB_MODE=1, requesters 0 and 2 continuously valid -> requester 0 wins every cycle; requester 2 is granted only once FIFO 0 is empty.
- Async reset mid-lock: assert reset while LOCKED with 2 queued packets -> l2req_valid = 0 immediately (before the next edge); all FIFOs are empty after release.
